// File: rtl/reg_scan_pkg.sv
// Shared encodings for the register-scan sequencer.
// REG_SCAN_HDR_EN adds the HDR state and the sweep header beat.
package reg_scan_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
`ifdef REG_SCAN_HDR_EN
    S_HDR   = 3'd1,
`endif
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_GAP   = 3'd4,
    S_DRAIN = 3'd5
  } state_t;

  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;
  localparam int          GAP_CYC  = 3;
  localparam int          BEAT_W   = 33;
  localparam logic [7:0]  HDR_PAD  = 8'h00;

  // header layout: {base[15:0], pad[7:0], count[7:0]}
  function automatic logic [31:0] hdr_word(input logic [15:0] base, input logic [7:0] cnt);
    return {base, HDR_PAD, cnt};
  endfunction
endpackage

// File: rtl/reg_scan_fifo.sv
// Synchronous FIFO with an AXIS-style read side; data reads as zero while empty.
module reg_scan_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [W-1:0]               rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          wr_ok, rd_ok;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : mem[rptr];
  assign wr_ok    = wr_en && !full;
  assign rd_ok    = rd_valid && rd_ready;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(1);
      if (rd_ok) rptr <= rptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/reg_scan_axis.sv
// Sweeps a range of LMAC registers, one read outstanding, and streams the words out.
// Optional header beat under REG_SCAN_HDR_EN.
module reg_scan_axis
  import reg_scan_pkg::*;
#(
  parameter int ADDR_STRIDE = 4,
  parameter int TIMEOUT_CYC = 64,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        reg_clk,
  input  logic        reset,
  input  logic        scan_go,
  input  logic [15:0] scan_base,
  input  logic [7:0]  scan_count,
  output logic        start,
  output logic [15:0] address,
  input  logic        reg_rd_done_out,
  input  logic [31:0] mac_regdout,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        scan_busy,
  output logic        scan_done,
  output logic        scan_err
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t            state, next_state;
  logic [15:0]       cur_addr;
  logic [7:0]        remain;
  logic [TW-1:0]     timer;
  logic [1:0]        gap_cnt;
  logic              wr_en;
  logic [BEAT_W-1:0] wr_data;
  logic              full, empty, rd_fire, drain_fin, timeout, last_rd, gap_end;
  logic [CW-1:0]     fcount;

  reg_scan_fifo #(.DEPTH(FIFO_DEPTH), .W(BEAT_W)) u_fifo (
    .clk      (reg_clk),
    .rst      (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_ready (m_axis_tready),
    .rd_valid (m_axis_tvalid),
    .rd_data  ({m_axis_tlast, m_axis_tdata}),
    .full     (full),
    .empty    (empty),
    .count    (fcount)
  );

  assign address   = cur_addr;
  assign rd_fire   = m_axis_tvalid && m_axis_tready;
  assign timeout   = (timer == TW'(TIMEOUT_CYC - 1));
  assign last_rd   = (remain == 8'd1);
  assign gap_end   = (gap_cnt == 2'(GAP_CYC - 1));
  // finish as the last beat leaves so scan_done lands the cycle after the transfer
  assign drain_fin = (state == S_DRAIN) && (empty || (fcount == CW'(1) && rd_fire));

  always_ff @(posedge reg_clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (scan_go) begin
`ifdef REG_SCAN_HDR_EN
        next_state = S_HDR;
`else
        next_state = (scan_count != 8'd0) ? S_ISSUE : S_DRAIN;
`endif
      end
`ifdef REG_SCAN_HDR_EN
      S_HDR:   next_state = (remain != 8'd0) ? S_ISSUE : S_DRAIN;
`endif
      S_ISSUE: if (!full) next_state = S_WAIT;
      S_WAIT: begin
        if (reg_rd_done_out) next_state = last_rd ? S_DRAIN : S_GAP;
        else if (timeout)    next_state = S_DRAIN;
      end
      S_GAP:   if (gap_end) next_state = S_ISSUE;
      S_DRAIN: if (drain_fin) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    start     = 1'b0;
    wr_en     = 1'b0;
    wr_data   = '0;
    scan_busy = (state != S_IDLE);
    case (state)
`ifdef REG_SCAN_HDR_EN
      S_HDR: begin
        wr_en   = 1'b1;
        wr_data = {remain == 8'd0, hdr_word(cur_addr, remain)};
      end
`endif
      S_ISSUE: start = !full;
      S_WAIT: begin
        if (reg_rd_done_out) begin
          wr_en   = 1'b1;
          wr_data = {last_rd, mac_regdout};
        end else if (timeout) begin
          wr_en   = 1'b1;
          wr_data = {1'b1, ERR_WORD};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge reg_clk or posedge reset) begin
    if (reset) begin
      cur_addr  <= '0;
      remain    <= '0;
      timer     <= '0;
      gap_cnt   <= '0;
      scan_err  <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= drain_fin;
      case (state)
        S_IDLE: if (scan_go) begin
          cur_addr <= scan_base;
          remain   <= scan_count;
          scan_err <= 1'b0;
        end
        S_ISSUE: if (start) timer <= '0;
        S_WAIT: begin
          if (reg_rd_done_out) begin
            remain  <= remain - 8'd1;
            gap_cnt <= '0;
          end else if (timeout) begin
            scan_err <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt + 2'd1;
          if (gap_end) cur_addr <= cur_addr + 16'(ADDR_STRIDE);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_scan_axis.sv
// Scoreboard bench for reg_scan_axis with a small LMAC read responder model.
module tb_reg_scan_axis;
  logic        reg_clk = 1'b0;
  logic        reset;
  logic        scan_go;
  logic [15:0] scan_base;
  logic [7:0]  scan_count;
  logic        start;
  logic [15:0] address;
  logic        reg_rd_done_out;
  logic [31:0] mac_regdout;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        scan_busy, scan_done, scan_err;

  reg_scan_axis dut (
    .reg_clk(reg_clk), .reset(reset), .scan_go(scan_go), .scan_base(scan_base),
    .scan_count(scan_count), .start(start), .address(address),
    .reg_rd_done_out(reg_rd_done_out), .mac_regdout(mac_regdout),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .scan_busy(scan_busy), .scan_done(scan_done), .scan_err(scan_err)
  );

  always #5 reg_clk = ~reg_clk;

`ifdef REG_SCAN_HDR_EN
  localparam int STALL_STARTS = 3;
`else
  localparam int STALL_STARTS = 4;
`endif

  int checks = 0, errors = 0;
  int cyc = 0;
  int n_starts = 0, last_start_cyc = 0, done_pulses = 0;
  int start_cyc[$];
  logic [32:0] exp_beats[$];
  logic [15:0] exp_addr[$];
  logic        resp_en = 1'b1;
  logic        stall_prev = 1'b0;
  logic [32:0] stall_val = '0;

  always @(posedge reg_clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // LMAC responder: done two cycles after each start, data = {C0DE, address}
  initial begin : responder
    int dly;
    logic [15:0] rsp_addr;
    dly = 0; rsp_addr = '0;
    reg_rd_done_out = 1'b0; mac_regdout = '0;
    forever begin
      @(negedge reg_clk);
      reg_rd_done_out = 1'b0;
      if (reset) dly = 0;
      else begin
        if (dly > 0) begin
          dly--;
          if (dly == 0) begin
            reg_rd_done_out = 1'b1;
            mac_regdout = {16'hC0DE, rsp_addr};
          end
        end
        if (start) begin
          n_starts++;
          last_start_cyc = cyc;
          start_cyc.push_back(cyc);
          if (exp_addr.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_start: got address %0h expected no start", address);
          end else check("start_address", address, exp_addr.pop_front());
          if (resp_en) begin dly = 2; rsp_addr = address; end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted beat, checks stall stability
  initial begin : monitor
    logic [32:0] e;
    forever begin
      @(negedge reg_clk);
      if (scan_done) done_pulses++;
      if (stall_prev && m_axis_tvalid)
        check("stall_stable", {m_axis_tlast, m_axis_tdata}, stall_val);
      stall_prev = m_axis_tvalid && !m_axis_tready;
      stall_val  = {m_axis_tlast, m_axis_tdata};
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_beats.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got %0h expected none", {m_axis_tlast, m_axis_tdata});
        end else begin
          e = exp_beats.pop_front();
          check("beat", {m_axis_tlast, m_axis_tdata}, e);
        end
      end
    end
  end

  task automatic expect_hdr(input logic [15:0] b, input logic [7:0] c);
`ifdef REG_SCAN_HDR_EN
    exp_beats.push_back({c == 8'd0, b, 8'h00, c});
`endif
  endtask

  task automatic go(input logic [15:0] b, input logic [7:0] c, output int gc);
    @(posedge reg_clk); #1;
    scan_go = 1'b1; scan_base = b; scan_count = c; gc = cyc;
    @(posedge reg_clk); #1;
    scan_go = 1'b0;
    @(negedge reg_clk);
    check("busy_after_go", scan_busy, 1);
    check("err_clear_on_go", scan_err, 0);
    check("address_latched", address, b);
`ifdef REG_SCAN_HDR_EN
    check("first_start_cycle1", start, 0);
`else
    if (c != 8'd0) check("first_start_cycle1", start, 1);
`endif
  endtask

  task automatic wait_done(input int budget, output int dc);
    dc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge reg_clk);
      if (scan_done) begin dc = cyc; break; end
    end
    checks++;
    if (dc < 0) begin errors++; $display("FAIL wait_done: got timeout expected scan_done"); end
    check("busy_low_at_done", scan_busy, 0);
    @(negedge reg_clk);
    check("done_one_cycle", scan_done, 0);
  endtask

  task automatic check_idle_outputs(input string nm);
    check({nm, "_start"}, start, 0);
    check({nm, "_address"}, address, 0);
    check({nm, "_tvalid"}, m_axis_tvalid, 0);
    check({nm, "_tdata"}, m_axis_tdata, 0);
    check({nm, "_tlast"}, m_axis_tlast, 0);
    check({nm, "_busy"}, scan_busy, 0);
    check({nm, "_done"}, scan_done, 0);
    check({nm, "_err"}, scan_err, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin : stim
    int gc, dc, s0, dp0, found;
    reset = 1'b1; scan_go = 1'b0; scan_base = '0; scan_count = '0; m_axis_tready = 1'b1;
    repeat (3) @(negedge reg_clk);
    check_idle_outputs("reset");
    @(posedge reg_clk); #1 reset = 1'b0;

    // basic sweep of three registers
    s0 = n_starts; dp0 = done_pulses; start_cyc.delete();
    expect_hdr(16'h0100, 8'd3);
    exp_beats.push_back({1'b0, 32'hC0DE_0100});
    exp_beats.push_back({1'b0, 32'hC0DE_0104});
    exp_beats.push_back({1'b1, 32'hC0DE_0108});
    exp_addr.push_back(16'h0100); exp_addr.push_back(16'h0104); exp_addr.push_back(16'h0108);
    go(16'h0100, 8'd3, gc);
    wait_done(200, dc);
    check("t1_starts", n_starts - s0, 3);
    check("t1_start_spacing", start_cyc[1] - start_cyc[0], 6);
    check("t1_done_pulses", done_pulses - dp0, 1);
    check("t1_queue_empty", exp_beats.size(), 0);

    // back-pressure throttles the sweep
    m_axis_tready = 1'b0;
    s0 = n_starts; dp0 = done_pulses;
    expect_hdr(16'h0200, 8'd6);
    for (int i = 0; i < 5; i++) exp_beats.push_back({1'b0, 32'hC0DE_0200 + 32'(4 * i)});
    exp_beats.push_back({1'b1, 32'hC0DE_0214});
    for (int i = 0; i < 6; i++) exp_addr.push_back(16'h0200 + 16'(4 * i));
    go(16'h0200, 8'd6, gc);
    repeat (60) @(negedge reg_clk);
    check("t2_stalled_starts", n_starts - s0, STALL_STARTS);
    check("t2_start_low", start, 0);
    check("t2_tvalid_held", m_axis_tvalid, 1);
    @(posedge reg_clk); #1 m_axis_tready = 1'b1;
    wait_done(300, dc);
    check("t2_starts", n_starts - s0, 6);
    check("t2_queue_empty", exp_beats.size(), 0);

    // read timeout
    resp_en = 1'b0;
    s0 = n_starts; dp0 = done_pulses;
    expect_hdr(16'h0300, 8'd2);
    exp_beats.push_back({1'b1, 32'hDEAD_BEEF});
    exp_addr.push_back(16'h0300);
    go(16'h0300, 8'd2, gc);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge reg_clk);
      if (m_axis_tvalid && m_axis_tdata == 32'hDEAD_BEEF) begin found = 1; break; end
    end
    check("t3_err_beat_seen", found, 1);
    // timeout fires on the 64th WAIT cycle; the beat is visible the cycle after
    check("t3_err_latency", cyc - last_start_cyc, 65);
    wait_done(50, dc);
    check("t3_scan_err", scan_err, 1);
    check("t3_starts", n_starts - s0, 1);
    check("t3_done_pulses", done_pulses - dp0, 1);
    resp_en = 1'b1;

    // address wrap (go also checks scan_err cleared)
    s0 = n_starts;
    expect_hdr(16'hFFFC, 8'd2);
    exp_beats.push_back({1'b0, 32'hC0DE_FFFC});
    exp_beats.push_back({1'b1, 32'hC0DE_0000});
    exp_addr.push_back(16'hFFFC); exp_addr.push_back(16'h0000);
    go(16'hFFFC, 8'd2, gc);
    wait_done(200, dc);
    check("t4_starts", n_starts - s0, 2);
    check("t4_queue_empty", exp_beats.size(), 0);

    // empty sweep
    s0 = n_starts; dp0 = done_pulses;
    expect_hdr(16'h1234, 8'd0);
    go(16'h1234, 8'd0, gc);
    wait_done(20, dc);
`ifdef REG_SCAN_HDR_EN
    check("t5_done_cycle", dc - gc, 3);
`else
    check("t5_done_cycle", dc - gc, 2);
`endif
    check("t5_starts", n_starts - s0, 0);
    check("t5_queue_empty", exp_beats.size(), 0);

    // reset while a read is outstanding with beats buffered
    m_axis_tready = 1'b0;
    s0 = n_starts;
    expect_hdr(16'h0400, 8'd4);
    for (int i = 0; i < 4; i++) begin
      exp_beats.push_back({i == 3, 32'hC0DE_0400 + 32'(4 * i)});
      exp_addr.push_back(16'h0400 + 16'(4 * i));
    end
    go(16'h0400, 8'd4, gc);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge reg_clk);
      if (n_starts - s0 == 3) begin found = 1; break; end
    end
    check("t6_reached_wait", found, 1);
    @(posedge reg_clk); #1 reset = 1'b1;
    #2;
    check_idle_outputs("midreset");
    exp_beats.delete(); exp_addr.delete();
    repeat (2) @(negedge reg_clk);
    @(posedge reg_clk); #1 reset = 1'b0; m_axis_tready = 1'b1;
    s0 = n_starts; dp0 = done_pulses;
    expect_hdr(16'h0500, 8'd1);
    exp_beats.push_back({1'b1, 32'hC0DE_0500});
    exp_addr.push_back(16'h0500);
    go(16'h0500, 8'd1, gc);
    wait_done(100, dc);
    check("t6_starts", n_starts - s0, 1);
    check("t6_done_pulses", done_pulses - dp0, 1);
    check("t6_queue_empty", exp_beats.size(), 0);

    repeat (3) @(negedge reg_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
